// File: rtl/arr_pkg.sv
// Shared types and helpers for the array-memory arbiter slice.
package arr_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_DEPTH  = 2;

    // Address width for a given depth, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned DEF_ADDR_W = addr_w(DEF_DEPTH);

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arr_if.sv
// Requester/host bundle between the datapath FSMs and the array arbiter.
interface arr_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 1,
    parameter int unsigned DATA_W = arr_pkg::DEF_DATA_W
);
    logic                     host_en;
    logic                     host_we;
    logic [ADDR_W-1:0]        host_addr;
    logic [DATA_W-1:0]        host_wdata;
    logic [DATA_W-1:0]        host_rdata;
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          lock;
    logic [NREQ-1:0]          we;
    logic [NREQ*ADDR_W-1:0]   addr;
    logic [NREQ*DATA_W-1:0]   wdata;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          rvalid;
    logic [DATA_W-1:0]        rdata;
    logic                     lock_owner_v;

    modport master (
        output host_en, host_we, host_addr, host_wdata,
        output req, lock, we, addr, wdata,
        input  host_rdata, gnt, rvalid, rdata, lock_owner_v
    );

    modport slave (
        input  host_en, host_we, host_addr, host_wdata,
        input  req, lock, we, addr, wdata,
        output host_rdata, gnt, rvalid, rdata, lock_owner_v
    );
endinterface

// File: rtl/arr_mem.sv
// Single-port array RAM with registered read address; out-of-range reads return 0.
module arr_mem
    import arr_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = addr_w(DEPTH),
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              oor_q, oor_d;
    logic              in_range_c;

    // Read address only moves on a read, so rdata holds the last read.
    always_comb begin
        in_range_c = 32'(addr) < DEPTH;
        raddr_d    = raddr_q;
        oor_d      = oor_q;
        if (en && !we) begin
            raddr_d = addr;
            oor_d   = !in_range_c;
        end
    end

    always_ff @(posedge clk) begin
        raddr_q <= raddr_d;
        oor_q   <= oor_d;
        if (en && we && in_range_c) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = oor_q ? '0 : mem_q[raddr_q];

endmodule

// File: rtl/arr_arbiter.sv
// Round-robin arbiter with lock and host override in front of one shared array RAM.
module arr_arbiter
    import arr_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = addr_w(DEPTH),
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input logic  clk,
    input logic  rst_n,
    arr_if.slave bus
);
    localparam int unsigned PTR_W = addr_w(NREQ);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic              lock_v_q, lock_v_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic              host_rd_q, host_rd_d;
    logic [NREQ-1:0]   gnt_c;
    logic              found_c;
    logic              mem_en_c, mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] mem_rdata;

    // Grant: host blocks everyone, lock owner is exclusive, otherwise scan from rr_ptr.
    always_comb begin
        gnt_c   = '0;
        found_c = 1'b0;
        if (rst_n && !bus.host_en) begin
            if (lock_v_q) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (32'(i) == 32'(owner_q)) gnt_c[i] = bus.req[i];
                end
            end else begin
                for (int k = 0; k < int'(NREQ); k++) begin
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (!found_c && bus.req[i] &&
                            32'(i) == (32'(rr_ptr_q) + 32'(k)) % NREQ) begin
                            gnt_c[i] = 1'b1;
                            found_c  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Memory port mux and next state for pointer, lock and read-return flags.
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        lock_v_d    = lock_v_q;
        rvalid_d    = gnt_c & ~bus.we;
        host_rd_d   = rst_n && bus.host_en && !bus.host_we;

        if (rst_n && bus.host_en) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.host_we;
            mem_addr_c  = bus.host_addr;
            mem_wdata_c = bus.host_wdata;
        end

        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_c[i]) begin
                mem_en_c    = 1'b1;
                mem_we_c    = bus.we[i];
                mem_addr_c  = bus.addr[i*ADDR_W +: ADDR_W];
                mem_wdata_c = bus.wdata[i*DATA_W +: DATA_W];
                rr_ptr_d    = PTR_W'((i + 1) % int'(NREQ));
                if (!lock_v_q && bus.lock[i]) begin
                    lock_v_d = 1'b1;
                    owner_d  = PTR_W'(i);
                end
            end
        end

        // Owner dropping lock releases at this edge, even on its own last access.
        if (lock_v_q) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (32'(i) == 32'(owner_q) && !bus.lock[i]) lock_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            lock_v_q  <= 1'b0;
            rvalid_q  <= '0;
            host_rd_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            lock_v_q  <= lock_v_d;
            rvalid_q  <= rvalid_d;
            host_rd_q <= host_rd_d;
        end
    end

    arr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en_c),
        .we    (mem_we_c),
        .addr  (mem_addr_c),
        .wdata (mem_wdata_c),
        .rdata (mem_rdata)
    );

    assign bus.gnt          = gnt_c;
    assign bus.rvalid       = rvalid_q;
    assign bus.lock_owner_v = lock_v_q;
    assign bus.rdata        = (|rvalid_q) ? mem_rdata : '0;
    assign bus.host_rdata   = host_rd_q ? mem_rdata : '0;

endmodule
